// File: rtl/spi_mem_arbiter.sv
// rtl/spi_mem_arbiter.sv - round-robin ibus/dbus arbiter serialising each access as one SPI SRAM transaction
module spi_mem_arbiter #(
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02,
  parameter int         CS_IDLE   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ibus_adr,
  input  logic        ibus_cyc,
  output logic [31:0] ibus_rdt,
  output logic        ibus_ack,
  input  logic [31:0] dbus_adr,
  input  logic [31:0] dbus_dat,
  input  logic [3:0]  dbus_sel,
  input  logic        dbus_we,
  input  logic        dbus_cyc,
  output logic [31:0] dbus_rdt,
  output logic        dbus_ack,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_CMD, S_ADDR, S_DATA, S_DONE, S_GAP
  } state_t;

  // DONE itself counts as the first CS-high cycle, so GAP covers the rest
  localparam logic [7:0] GAP_LOAD = (CS_IDLE > 1) ? 8'(CS_IDLE - 2) : 8'd0;
  localparam bit         HAS_GAP  = (CS_IDLE > 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic        empty_q, empty_d;
  logic [63:0] sh_q, sh_d;
  logic [6:0]  nbits_q, nbits_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [31:0] rx_q, rx_d;
  logic [7:0]  gap_q, gap_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        iack_q, iack_d;
  logic        dack_q, dack_d;
  logic [31:0] irdt_q, irdt_d;
  logic [31:0] drdt_q, drdt_d;

  logic [1:0]  lo, hi;
  logic [2:0]  nbytes;
  logic [31:0] wdat_sh, wfield, rx_fin, rd_word;
  logic [6:0]  nxt_cnt;
  logic        gnt;
  logic        unused_bits;

  assign unused_bits = ^{ibus_adr[31:24], ibus_adr[1:0], dbus_adr[31:24], dbus_adr[1:0]};

  always_comb begin
    lo = 2'd0;
    hi = 2'd0;
    for (int i = 3; i >= 0; i--) if (dbus_sel[i]) lo = 2'(i);
    for (int i = 0; i < 4; i++) if (dbus_sel[i]) hi = 2'(i);
  end

  // Write bytes lo..hi go out ascending, so byte lo lands in the MSB slot
  assign nbytes  = {1'b0, hi} - {1'b0, lo} + 3'd1;
  assign wdat_sh = dbus_dat >> {lo, 3'b000};
  assign wfield  = {wdat_sh[7:0], wdat_sh[15:8], wdat_sh[23:16], wdat_sh[31:24]};
  assign rx_fin  = {rx_q[30:0], spi_miso};
  assign rd_word = {rx_fin[7:0], rx_fin[15:8], rx_fin[23:16], rx_fin[31:24]};
  assign nxt_cnt = cnt_q + 7'd1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    empty_d = empty_q;
    sh_d    = sh_q;
    nbits_d = nbits_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    gap_d   = gap_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    iack_d  = 1'b0;
    dack_d  = 1'b0;
    irdt_d  = irdt_q;
    drdt_d  = drdt_q;
    gnt     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ibus_cyc || dbus_cyc) begin
          gnt     = (ibus_cyc && dbus_cyc) ? ~last_q : dbus_cyc;
          last_d  = gnt;
          gnt_d   = gnt;
          state_d = S_LATCH;
          if (gnt) begin
            we_d    = dbus_we;
            empty_d = dbus_we && (dbus_sel == 4'b0000);
            if (dbus_we) begin
              sh_d    = {CMD_WRITE, dbus_adr[23:2], lo, wfield};
              nbits_d = 7'd32 + {1'b0, nbytes, 3'b000};
            end else begin
              sh_d    = {CMD_READ, dbus_adr[23:2], 2'b00, 32'h0};
              nbits_d = 7'd64;
            end
          end else begin
            we_d    = 1'b0;
            empty_d = 1'b0;
            sh_d    = {CMD_READ, ibus_adr[23:2], 2'b00, 32'h0};
            nbits_d = 7'd64;
          end
        end
      end
      S_LATCH: begin
        if (empty_q) begin
          state_d = S_DONE;
          dack_d  = 1'b1;
        end else begin
          state_d = S_CMD;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = sh_q[63];
          sh_d    = {sh_q[62:0], 1'b0};
          cnt_d   = 7'd0;
        end
      end
      S_CMD, S_ADDR, S_DATA: begin
        if (!sck_q) begin
          sck_d = 1'b1;
        end else begin
          rx_d = rx_fin;
          if (cnt_q == nbits_q - 7'd1) begin
            state_d = S_DONE;
            cs_n_d  = 1'b1;
            sck_d   = 1'b0;
            mosi_d  = 1'b0;
            if (gnt_q) dack_d = 1'b1;
            else       iack_d = 1'b1;
            if (!we_q) begin
              if (gnt_q) drdt_d = rd_word;
              else       irdt_d = rd_word;
            end
          end else begin
            sck_d   = 1'b0;
            mosi_d  = sh_q[63];
            sh_d    = {sh_q[62:0], 1'b0};
            cnt_d   = nxt_cnt;
            state_d = (nxt_cnt < 7'd8) ? S_CMD : (nxt_cnt < 7'd32) ? S_ADDR : S_DATA;
          end
        end
      end
      S_DONE: begin
        gap_d   = GAP_LOAD;
        state_d = HAS_GAP ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (gap_q == 8'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      empty_q <= 1'b0;
      sh_q    <= 64'h0;
      nbits_q <= 7'd0;
      cnt_q   <= 7'd0;
      rx_q    <= 32'h0;
      gap_q   <= 8'd0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      iack_q  <= 1'b0;
      dack_q  <= 1'b0;
      irdt_q  <= 32'h0;
      drdt_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      empty_q <= empty_d;
      sh_q    <= sh_d;
      nbits_q <= nbits_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      gap_q   <= gap_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      iack_q  <= iack_d;
      dack_q  <= dack_d;
      irdt_q  <= irdt_d;
      drdt_q  <= drdt_d;
    end
  end

  assign spi_cs_n = cs_n_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign ibus_ack = iack_q;
  assign dbus_ack = dack_q;
  assign ibus_rdt = irdt_q;
  assign dbus_rdt = drdt_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb/tb_spi_mem_arbiter.sv - directed and randomized checks of spi_mem_arbiter against an SRAM model
module tb_spi_mem_arbiter;
  localparam int CS_IDLE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ibus_adr = '0, dbus_adr = '0, dbus_dat = '0;
  logic        ibus_cyc = 1'b0, dbus_cyc = 1'b0, dbus_we = 1'b0;
  logic [3:0]  dbus_sel = '0;
  logic [31:0] ibus_rdt, dbus_rdt;
  logic        ibus_ack, dbus_ack, spi_cs_n, spi_sck, spi_mosi;
  logic        spi_miso = 1'b0;

  spi_mem_arbiter #(.CMD_READ(8'h03), .CMD_WRITE(8'h02), .CS_IDLE(CS_IDLE)) dut (
    .clk(clk), .rst(rst),
    .ibus_adr(ibus_adr), .ibus_cyc(ibus_cyc), .ibus_rdt(ibus_rdt), .ibus_ack(ibus_ack),
    .dbus_adr(dbus_adr), .dbus_dat(dbus_dat), .dbus_sel(dbus_sel), .dbus_we(dbus_we),
    .dbus_cyc(dbus_cyc), .dbus_rdt(dbus_rdt), .dbus_ack(dbus_ack),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int overlap = 0, idle_bad = 0;

  always @(negedge clk) begin
    if (ibus_ack && dbus_ack) overlap++;
    if (spi_cs_n && (spi_mosi || spi_sck)) idle_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SPI SRAM model: bytes absent from the map read as a fixed address hash
  logic [7:0]  mem [logic [23:0]];
  logic [7:0]  ref_mem [logic [23:0]];
  int          bitn = 0, nbyte = 0;
  logic [31:0] hdr = '0, dword = '0;
  logic [7:0]  cur = '0;
  logic [7:0]  q_cmd[$];
  logic [23:0] q_addr[$];
  int          q_nb[$];
  logic [31:0] q_data[$];

  function automatic logic [7:0] dflt(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  always @(negedge spi_cs_n) begin
    bitn = 0; nbyte = 0; dword = '0; hdr = '0;
  end

  always @(posedge spi_sck) if (!spi_cs_n) begin
    int j;
    logic [7:0] b;
    j = bitn;
    if (j < 32) hdr = {hdr[30:0], spi_mosi};
    else begin
      cur = {cur[6:0], spi_mosi};
      if (hdr[31:24] == 8'h03) begin
        b = mem_rd(hdr[23:0] + 24'((j - 32) / 8));
        spi_miso = b[7 - ((j - 32) % 8)];
      end
      if ((j - 32) % 8 == 7) begin
        if (nbyte < 4) dword[8*nbyte +: 8] = cur;
        if (hdr[31:24] == 8'h02) mem[hdr[23:0] + 24'(nbyte)] = cur;
        nbyte++;
      end
    end
    bitn = j + 1;
  end

  always @(posedge spi_cs_n) if (bitn > 0) begin
    q_cmd.push_back(hdr[31:24]);
    q_addr.push_back(hdr[23:0]);
    q_nb.push_back(nbyte);
    q_data.push_back(dword);
    bitn = 0;
  end

  // Reference: what the SRAM should see and what the bus should get back
  logic [31:0] exp_irdt = '0, exp_drdt = '0;
  bit          exp_last = 1'b1;

  function automatic int op_lo(input bit is_d, input bit we, input logic [3:0] sel);
    if (!(is_d && we)) return 0;
    for (int i = 0; i < 4; i++) if (sel[i]) return i;
    return 0;
  endfunction

  function automatic int op_nb(input bit is_d, input bit we, input logic [3:0] sel);
    int lo, hi;
    if (!(is_d && we)) return 4;
    lo = -1; hi = -1;
    for (int i = 0; i < 4; i++) if (sel[i]) begin
      if (lo < 0) lo = i;
      hi = i;
    end
    return (lo < 0) ? 0 : hi - lo + 1;
  endfunction

  function automatic int op_lat(input bit is_d, input bit we, input logic [3:0] sel);
    int nb;
    nb = op_nb(is_d, we, sel);
    return (nb == 0) ? 1 : 2 * (32 + 8 * nb) + 1;
  endfunction

  task automatic check_op(input bit is_d, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input bit we, input logic [31:0] obs_rdt,
                          input string tag);
    logic [23:0] base;
    logic [31:0] w;
    int lo, nb;
    base = {adr[23:2], 2'b00};
    lo = op_lo(is_d, we, sel);
    nb = op_nb(is_d, we, sel);
    w = '0;
    if (is_d && we) begin
      for (int i = 0; i < nb; i++) begin
        w[8*i +: 8] = dat[8*(lo+i) +: 8];
        ref_mem[base + 24'(lo + i)] = dat[8*(lo+i) +: 8];
      end
      chk({tag, "_drdt_hold"}, 64'(obs_rdt), 64'(exp_drdt));
    end else begin
      for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_rd(base + 24'(i));
      chk({tag, "_rdt"}, 64'(obs_rdt), 64'(w));
      if (is_d) exp_drdt = w;
      else      exp_irdt = w;
      w = '0;
    end
    if (nb == 0) chk({tag, "_no_spi"}, 64'(q_cmd.size()), 64'd0);
    else begin
      chk({tag, "_spi_logged"}, 64'(q_cmd.size() > 0), 64'd1);
      if (q_cmd.size() > 0) begin
        chk({tag, "_cmd"}, 64'(q_cmd.pop_front()), (is_d && we) ? 64'h02 : 64'h03);
        chk({tag, "_addr"}, 64'(q_addr.pop_front()), 64'(base + 24'(lo)));
        chk({tag, "_nbytes"}, 64'(q_nb.pop_front()), 64'(nb));
        chk({tag, "_mosi_data"}, 64'(q_data.pop_front()), 64'(w));
      end
    end
  endtask

  task automatic run_one(input bit is_d, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input bit we, input string tag);
    int k, e, cs_edge;
    bit other;
    logic [31:0] obs;
    @(negedge clk);
    if (is_d) begin
      dbus_adr = adr; dbus_dat = dat; dbus_sel = sel; dbus_we = we; dbus_cyc = 1'b1;
    end else begin
      ibus_adr = adr; ibus_cyc = 1'b1;
    end
    k = cyc_n + 1;
    e = -1; cs_edge = -1; other = 1'b0; obs = '0;
    for (int t = 0; t < 400 && e < 0; t++) begin
      @(negedge clk);
      if (!spi_cs_n && cs_edge < 0) cs_edge = cyc_n;
      if (is_d ? ibus_ack : dbus_ack) other = 1'b1;
      if (is_d ? dbus_ack : ibus_ack) begin
        e = cyc_n;
        obs = is_d ? dbus_rdt : ibus_rdt;
      end
    end
    ibus_cyc = 1'b0; dbus_cyc = 1'b0;
    chk({tag, "_ack_lat"}, 64'(e - k), 64'(op_lat(is_d, we, sel)));
    chk({tag, "_cs_edge"}, 64'(cs_edge), (op_nb(is_d, we, sel) == 0) ? 64'(-1) : 64'(k + 1));
    chk({tag, "_other_ack"}, 64'(other), 64'd0);
    check_op(is_d, adr, dat, sel, we, obs, tag);
    chk({tag, "_other_rdt"}, is_d ? 64'(ibus_rdt) : 64'(dbus_rdt), is_d ? 64'(exp_irdt) : 64'(exp_drdt));
    exp_last = is_d;
    repeat (CS_IDLE + 2) @(negedge clk);
  endtask

  task automatic run_pair(input logic [31:0] iadr, input logic [31:0] dadr, input logic [31:0] ddat,
                          input logic [3:0] dsel, input bit dwe, input string tag);
    bit first_d;
    int k, ei, ed, li, ld;
    first_d = !exp_last;
    @(negedge clk);
    ibus_adr = iadr; ibus_cyc = 1'b1;
    dbus_adr = dadr; dbus_dat = ddat; dbus_sel = dsel; dbus_we = dwe; dbus_cyc = 1'b1;
    k = cyc_n + 1;
    ei = -1; ed = -1;
    for (int t = 0; t < 700 && (ei < 0 || ed < 0); t++) begin
      @(negedge clk);
      if (ibus_ack && ei < 0) begin
        ei = cyc_n; ibus_cyc = 1'b0;
        check_op(1'b0, iadr, '0, 4'h0, 1'b0, ibus_rdt, {tag, "_i"});
      end
      if (dbus_ack && ed < 0) begin
        ed = cyc_n; dbus_cyc = 1'b0;
        check_op(1'b1, dadr, ddat, dsel, dwe, dbus_rdt, {tag, "_d"});
      end
    end
    ibus_cyc = 1'b0; dbus_cyc = 1'b0;
    li = op_lat(1'b0, 1'b0, 4'h0);
    ld = op_lat(1'b1, dwe, dsel);
    if (first_d) begin
      chk({tag, "_first_lat"}, 64'(ed - k), 64'(ld));
      chk({tag, "_second_gap"}, 64'(ei - ed), 64'(1 + CS_IDLE + li));
    end else begin
      chk({tag, "_first_lat"}, 64'(ei - k), 64'(li));
      chk({tag, "_second_gap"}, 64'(ed - ei), 64'(1 + CS_IDLE + ld));
    end
    exp_last = !first_d;
    repeat (CS_IDLE + 2) @(negedge clk);
  endtask

  initial begin
    int k;
    bit saw_ack;
    mem[24'h104] = 8'h13; mem[24'h105] = 8'h05; mem[24'h106] = 8'h00; mem[24'h107] = 8'h00;
    ref_mem[24'h104] = 8'h13; ref_mem[24'h105] = 8'h05; ref_mem[24'h106] = 8'h00; ref_mem[24'h107] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_cs_n", 64'(spi_cs_n), 64'd1);
    chk("rst_sck", 64'(spi_sck), 64'd0);
    chk("rst_mosi", 64'(spi_mosi), 64'd0);
    chk("rst_acks", 64'({ibus_ack, dbus_ack}), 64'd0);
    chk("rst_rdts", {ibus_rdt, dbus_rdt}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_one(1'b0, 32'h0000_0104, '0, 4'h0, 1'b0, "tp_iread");
    chk("tp_iread_value", 64'(ibus_rdt), 64'h0000_0513);
    run_one(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF, 1'b1, "tp_wr4");
    run_one(1'b1, 32'h0000_0203, 32'h00AA_0000, 4'b0100, 1'b1, "tp_wr1");
    run_one(1'b1, 32'h0000_0203, 32'hBBAA_0000, 4'b1100, 1'b1, "tp_wr2");
    run_one(1'b1, 32'h0000_0200, '0, 4'hF, 1'b0, "tp_dread");
    chk("tp_dread_value", 64'(dbus_rdt), 64'hBBAA_BEEF);
    run_one(1'b1, 32'h0000_0300, 32'h1234_5678, 4'b0000, 1'b1, "tp_sel0");
    run_one(1'b1, 32'h0000_0210, 32'h4433_2211, 4'b0101, 1'b1, "tp_noncontig");

    run_pair(32'h0000_0200, 32'h0000_0104, '0, 4'hF, 1'b0, "pair1");
    run_pair(32'h0000_0104, 32'h0000_0208, 32'hCAFE_F00D, 4'b0011, 1'b1, "pair2");
    run_one(1'b0, 32'h0000_0208, '0, 4'h0, 1'b0, "after_pair");
    run_pair(32'h0000_0200, 32'h0000_0208, '0, 4'h0, 1'b0, "pair3");

    @(negedge clk);
    ibus_adr = 32'h0000_0104; ibus_cyc = 1'b1;
    k = cyc_n + 1;
    while (cyc_n < k + 40) @(negedge clk);
    chk("abort_cs_active", 64'(spi_cs_n), 64'd0);
    rst = 1'b1; ibus_cyc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cs_n", 64'(spi_cs_n), 64'd1);
    chk("abort_sck", 64'(spi_sck), 64'd0);
    chk("abort_rdt_clear", {ibus_rdt, dbus_rdt}, 64'd0);
    saw_ack = 1'b0;
    for (int t = 0; t < 6; t++) begin
      if (ibus_ack || dbus_ack || !spi_cs_n) saw_ack = 1'b1;
      @(negedge clk);
    end
    chk("abort_quiet", 64'(saw_ack), 64'd0);
    q_cmd.delete(); q_addr.delete(); q_nb.delete(); q_data.delete();
    exp_irdt = '0; exp_drdt = '0; exp_last = 1'b1;
    run_pair(32'h0000_0104, 32'h0000_0200, '0, 4'hF, 1'b0, "post_rst_pair");
    run_one(1'b0, 32'h0000_0200, '0, 4'h0, 1'b0, "post_rst_read");

    for (int n = 0; n < 10; n++) begin
      logic [31:0] a, d;
      logic [3:0] s;
      a = 32'h0000_0400 | 32'($urandom_range(0, 255));
      d = $urandom;
      s = 4'($urandom);
      run_one(1'($urandom), a, d, s, 1'($urandom), $sformatf("rnd%0d", n));
    end
    for (int n = 0; n < 3; n++) begin
      logic [3:0] s;
      s = 4'($urandom_range(1, 15));
      run_pair(32'h0000_0400 | 32'($urandom_range(0, 255)), 32'h0000_0400 | 32'($urandom_range(0, 255)),
               $urandom, s, 1'($urandom), $sformatf("rpair%0d", n));
    end

    chk("ack_overlap", 64'(overlap), 64'd0);
    chk("idle_lines", 64'(idle_bad), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
